// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and register field positions for the
// multi-channel LED controller (led_ctrl and led_ctrl_chan).
package led_ctrl_pkg;

  // Per-channel output mode, stored in CHk[1:0].
  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  // Word address of the global control register; channels follow at 1..CH.
  localparam int CTRL_ADDR = 32'd0;

  // CTRL register fields.
  localparam int EN_BIT    = 32'd0;
  localparam int PRESC_LSB = 32'd8;

  // CHk register fields.
  localparam int MODE_LSB  = 32'd0;
  localparam int INV_BIT   = 32'd2;
  localparam int DUTY_LSB  = 32'd16;

  // Extract the mode field from a channel register write word.
  function automatic led_mode_t mode_field(input logic [31:0] word);
    return led_mode_t'(word[MODE_LSB +: 2]);
  endfunction

endpackage

// File: rtl/led_ctrl_chan.sv
// led_ctrl_chan: one LED channel. Holds the channel's config register
// (MODE, DUTY, optional INV), its blink state and the registered pin.
// Build option: define LED_CTRL_INVERT_EN to store and apply CHk bit 2 (INV).
module led_ctrl_chan
  import led_ctrl_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_sel,
  input  logic [31:0]       wr_data,
  input  logic              en,
  input  logic [DUTY_W-1:0] phase,
  input  logic              wrap,
  output logic [31:0]       cfg,
  output logic              led
);

  led_mode_t         mode_r;
  logic [DUTY_W-1:0] duty_r;
  logic              inv_s;
  logic              blink_r;
  logic              sel_s;
  logic              out_s;
  logic              led_r;
  logic              unused_s;

  // Only a few bits of the write word belong to this channel.
  assign unused_s = ^wr_data;

  // Channel configuration register: MODE and DUTY.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= LED_OFF;
      duty_r <= '0;
    end else if (wr_sel) begin
      mode_r <= mode_field(wr_data);
      duty_r <= wr_data[DUTY_LSB +: DUTY_W];
    end
  end

`ifdef LED_CTRL_INVERT_EN
  logic inv_r;

  // Output inversion bit, stored only when the inversion option is built in.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_r <= 1'b0;
    end else if (wr_sel) begin
      inv_r <= wr_data[INV_BIT];
    end
  end

  assign inv_s = inv_r;
`else
  assign inv_s = 1'b0;
`endif

  // Blink state: toggles on each phase wrap, cleared outside BLINK mode or when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_r <= 1'b0;
    end else if (!en || (mode_r != LED_BLINK)) begin
      blink_r <= 1'b0;
    end else if (wrap) begin
      blink_r <= ~blink_r;
    end
  end

  // Mode selection, global gating, then optional inversion.
  always_comb begin
    sel_s = 1'b0;
    case (mode_r)
      LED_OFF:   sel_s = 1'b0;
      LED_ON:    sel_s = 1'b1;
      LED_BLINK: sel_s = blink_r;
      LED_PWM:   sel_s = (phase < duty_r);
      default:   sel_s = 1'b0;
    endcase
    if (!en) begin
      sel_s = 1'b0;
    end else begin
      sel_s = sel_s;
    end
    out_s = sel_s ^ inv_s;
  end

  // Registered LED pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r <= 1'b0;
    end else begin
      led_r <= out_s;
    end
  end

  // Register readback; unimplemented bits are zero.
  always_comb begin
    cfg                        = 32'd0;
    cfg[MODE_LSB +: 2]         = mode_r;
    cfg[INV_BIT]               = inv_s;
    cfg[DUTY_LSB +: DUTY_W]    = duty_r;
  end

  assign led = led_r;

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: memory-mapped multi-channel LED controller. Holds CTRL
// (enable + prescaler), the shared prescaler/phase timebase and the
// registered read port; each channel lives in led_ctrl_chan.
// Build option: define LED_CTRL_INVERT_EN for per-channel output inversion.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CH      = 8,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(CH+1)-1:0]   wr_addr,
  input  logic [31:0]               wr_data,
  input  logic                      rd_en,
  input  logic [$clog2(CH+1)-1:0]   rd_addr,
  output logic [31:0]               rd_data,
  output logic                      rd_valid,
  output logic [CH-1:0]             led
);

  localparam int AW = $clog2(CH + 1);

  logic               ctrl_en_r;
  logic [PRESC_W-1:0] ctrl_presc_r;
  logic [PRESC_W-1:0] pcnt_r;
  logic [DUTY_W-1:0]  phase_r;
  logic               tick_s;
  logic               wrap_s;
  logic               ctrl_sel_s;
  logic [31:0]        ctrl_rd_s;
  logic [31:0]        rd_mux_s;
  logic [31:0]        rd_data_r;
  logic               rd_valid_r;
  logic [31:0]        chan_cfg_s [CH];

  assign ctrl_sel_s = wr_en && (wr_addr == AW'(CTRL_ADDR));

  // CTRL register: global enable and prescaler reload value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_r    <= 1'b0;
      ctrl_presc_r <= '0;
    end else if (ctrl_sel_s) begin
      ctrl_en_r    <= wr_data[EN_BIT];
      ctrl_presc_r <= wr_data[PRESC_LSB +: PRESC_W];
    end
  end

  // Tick when the prescaler has reached (or passed) PRESC; wrap on the last phase step.
  always_comb begin
    if (ctrl_en_r && (pcnt_r >= ctrl_presc_r)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    wrap_s = tick_s && (&phase_r);
  end

  // Shared timebase: prescaler and phase, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_r  <= '0;
      phase_r <= '0;
    end else if (!ctrl_en_r) begin
      pcnt_r  <= '0;
      phase_r <= '0;
    end else if (tick_s) begin
      pcnt_r  <= '0;
      phase_r <= phase_r + DUTY_W'(1'b1);
    end else begin
      pcnt_r  <= pcnt_r + PRESC_W'(1'b1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    logic chan_sel_s;
    assign chan_sel_s = wr_en && (wr_addr == AW'(g + 1));

    led_ctrl_chan #(
      .DUTY_W (DUTY_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr_sel  (chan_sel_s),
      .wr_data (wr_data),
      .en      (ctrl_en_r),
      .phase   (phase_r),
      .wrap    (wrap_s),
      .cfg     (chan_cfg_s[g]),
      .led     (led[g])
    );
  end

  // CTRL readback image; unimplemented bits are zero.
  always_comb begin
    ctrl_rd_s                        = 32'd0;
    ctrl_rd_s[EN_BIT]                = ctrl_en_r;
    ctrl_rd_s[PRESC_LSB +: PRESC_W]  = ctrl_presc_r;
  end

  // Read mux over CTRL and all channels; unmatched addresses read as zero.
  always_comb begin
    rd_mux_s = 32'd0;
    if (rd_addr == AW'(CTRL_ADDR)) begin
      rd_mux_s = ctrl_rd_s;
    end else begin
      for (int k = 0; k < CH; k++) begin
        rd_mux_s = rd_mux_s | ((rd_addr == AW'(k + 1)) ? chan_cfg_s[k] : 32'd0);
      end
    end
  end

  // Registered read port: data captured at the strobe edge, valid one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'd0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_mux_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule
